// File: rtl/yarvi_lsu.sv
// yarvi load-store unit: byte/half/word/doubleword accesses with byte-lane store merging,
// sign/zero extended loads through a fixed-depth result pipeline, misalignment faults and
// the tohost halt protocol.
module yarvi_lsu #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DEPTH_LG2    = 10,
  parameter int unsigned LOAD_LATENCY = 1,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid,
  input  logic              writeenable,
  input  logic [ADDR_W-1:0] address,
  input  logic [XLEN-1:0]   writedata,
  input  logic [1:0]        sizelg2,
  input  logic [4:0]        readtag,
  input  logic              readsignextend,
  output logic              me_ready,
  output logic              me_readdatavalid,
  output logic [4:0]        me_readdatatag,
  output logic [XLEN-1:0]   me_readdata,
  output logic              me_fault,
  output logic              tohost_valid,
  output logic [31:0]       tohost_data
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned BLG2  = $clog2(NB);
  localparam int unsigned WORDS = 1 << DEPTH_LG2;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      tag;
    logic            fault;
    logic [XLEN-1:0] word;
    logic [BLG2-1:0] off;
    logic [1:0]      size;
    logic            signext;
  } stage_t;

  state_e          state_q;
  logic            tohost_valid_q;
  logic [31:0]     tohost_data_q;
  logic            st_fault_q;
  logic [XLEN-1:0] mem_q [WORDS];
  stage_t          pipe_q [LOAD_LATENCY];
  stage_t          stage_in;
  stage_t          last;

  logic                 accept;
  logic [DEPTH_LG2-1:0] word_idx;
  logic [BLG2-1:0]      byte_off;
  logic [2:0]           align_mask;
  logic                 oversize;
  logic                 misaligned;
  logic                 req_fault;
  logic                 is_tohost;
  logic                 st_go;
  logic                 th_go;
  logic                 st_fault;
  logic                 ld_go;
  logic [NB-1:0]        be_base;
  logic [NB-1:0]        byte_en;
  logic [XLEN-1:0]      wdata_rep;

  assign me_ready   = (state_q == StRun);
  assign accept     = valid & me_ready;
  assign word_idx   = address[DEPTH_LG2+BLG2-1:BLG2];
  assign byte_off   = address[BLG2-1:0];
  assign oversize   = {1'b0, sizelg2} > 3'(BLG2);
  assign misaligned = |(address[2:0] & align_mask);
  assign req_fault  = oversize | misaligned;
  // Full-width compare: aliases of the tohost word still write the array normally
  assign is_tohost  = (address == TOHOST_ADDR);
  assign st_go      = accept & writeenable & ~req_fault & ~is_tohost;
  assign th_go      = accept & writeenable & ~req_fault & is_tohost;
  assign st_fault   = accept & writeenable & req_fault;
  assign ld_go      = accept & ~writeenable;

  // Low address bits that must be zero for the requested size
  always_comb begin
    align_mask = 3'b000;
    unique case (sizelg2)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
  end

  // Replicate store data across lanes and build the byte enables for size at offset
  always_comb begin
    be_base   = '0;
    wdata_rep = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      int unsigned lane;
      lane                  = b & ((32'd1 << sizelg2) - 32'd1);
      wdata_rep[8*b +: 8]   = 8'(writedata >> (8 * lane));
      be_base[b]            = (b < (32'd1 << sizelg2));
    end
    byte_en = be_base << byte_off;
  end

  // Byte-masked array write; the array is deliberately not reset
  always_ff @(posedge clock) begin
    if (st_go) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Pipeline entry: the whole word is captured at the accepting edge
  always_comb begin
    stage_in = '{valid:   ld_go,
                 tag:     readtag,
                 fault:   req_fault,
                 word:    mem_q[word_idx],
                 off:     byte_off,
                 size:    sizelg2,
                 signext: readsignextend};
  end

  // Load result pipeline; reset drops every in-flight load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LOAD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < LOAD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Align, mask and extend the oldest stage; outputs read zero when no result is present
  always_comb begin
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ext;
    logic            sign;
    int unsigned     nbits;
    last    = pipe_q[LOAD_LATENCY-1];
    shifted = last.word >> {last.off, 3'b000};
    nbits   = 32'd8 << last.size;
    if (nbits >= XLEN) begin
      mask = '1;
      sign = 1'b0;
    end else begin
      mask = (XLEN'(1) << nbits) - XLEN'(1);
      // mask & ~(mask >> 1) isolates the top bit of the access
      sign = last.signext & |(shifted & (mask & ~(mask >> 1)));
    end
    ext = (shifted & mask) | (sign ? ~mask : '0);
    me_readdatavalid = last.valid;
    me_readdatatag   = last.valid ? last.tag : 5'd0;
    me_readdata      = (last.valid && !last.fault) ? ext : '0;
    me_fault         = (last.valid & last.fault) | st_fault_q;
  end

  // Run/halt state machine with registered tohost and store-fault pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StRun;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
      st_fault_q     <= 1'b0;
    end else begin
      tohost_valid_q <= th_go;
      st_fault_q     <= st_fault;
      if (th_go) tohost_data_q <= writedata[31:0];
      unique case (state_q)
        StRun:   if (th_go) state_q <= StHalt;
        StHalt:  state_q <= StHalt;
        default: state_q <= StRun;
      endcase
    end
  end

  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;

endmodule

// File: tb/tb_yarvi_lsu.sv
// Self-checking bench for yarvi_lsu: a 64-bit latency-3 instance driven by directed and random
// requests against a byte-array reference model, plus a 32-bit latency-1 instance for the
// oversize-fault and narrow-width cases.
module tb_yarvi_lsu;

  localparam int unsigned LAT    = 3;
  localparam int unsigned DLG2   = 4;
  localparam int          NMAX   = 4096;
  localparam int          INF    = 1 << 30;
  localparam logic [31:0] TOHOST = 32'h8000_1000;

  logic clock = 1'b0;
  logic reset_n = 1'b1;

  logic        v64 = 0, we64 = 0, se64 = 0;
  logic [31:0] a64 = 0;
  logic [63:0] wd64 = 0;
  logic [1:0]  sz64 = 0;
  logic [4:0]  tag64 = 0;
  logic        r64, rdv64, flt64, thv64;
  logic [4:0]  rtag64;
  logic [63:0] rd64;
  logic [31:0] thd64;

  logic        v32 = 0, we32 = 0, se32 = 0;
  logic [31:0] a32 = 0;
  logic [31:0] wd32 = 0;
  logic [1:0]  sz32 = 0;
  logic [4:0]  tag32 = 0;
  logic        r32, rdv32, flt32, thv32;
  logic [4:0]  rtag32;
  logic [31:0] rd32;
  logic [31:0] thd32;

  yarvi_lsu #(.XLEN(64), .ADDR_W(32), .DEPTH_LG2(DLG2), .LOAD_LATENCY(LAT),
              .TOHOST_ADDR(TOHOST)) u64 (
    .clock(clock), .reset_n(reset_n), .valid(v64), .writeenable(we64), .address(a64),
    .writedata(wd64), .sizelg2(sz64), .readtag(tag64), .readsignextend(se64),
    .me_ready(r64), .me_readdatavalid(rdv64), .me_readdatatag(rtag64), .me_readdata(rd64),
    .me_fault(flt64), .tohost_valid(thv64), .tohost_data(thd64)
  );

  yarvi_lsu #(.XLEN(32), .ADDR_W(32), .DEPTH_LG2(DLG2), .LOAD_LATENCY(1),
              .TOHOST_ADDR(TOHOST)) u32 (
    .clock(clock), .reset_n(reset_n), .valid(v32), .writeenable(we32), .address(a32),
    .writedata(wd32), .sizelg2(sz32), .readtag(tag32), .readsignextend(se32),
    .me_ready(r32), .me_readdatavalid(rdv32), .me_readdatatag(rtag32), .me_readdata(rd32),
    .me_fault(flt32), .tohost_valid(thv32), .tohost_data(thd32)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int neg_cnt = 0;
  int halt_from = INF;

  // Expected 64-bit instance outputs, indexed by falling-edge number
  bit        exp_v   [NMAX];
  bit [4:0]  exp_tag [NMAX];
  bit [63:0] exp_d   [NMAX];
  bit        exp_f   [NMAX];
  bit        exp_thv [NMAX];
  bit [31:0] exp_thd [NMAX];

  // Reference memory as plain little-endian bytes
  bit [7:0] mb [(1 << DLG2) * 8];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic int unsigned byte_base(input logic [31:0] a);
    return ((a >> 3) % (1 << DLG2)) * 8 + (a % 8);
  endfunction

  function automatic logic [63:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic se);
    int unsigned base = byte_base(a);
    int unsigned n = 1 << sz;
    logic [63:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (64'(mb[base + i]) << (8 * i));
    if (sz != 2'd3 && se && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  // One request slot on the 64-bit instance, driven just after a falling edge
  task automatic req64(input logic we, input logic [31:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic [4:0] tag, input logic se);
    int  k = neg_cnt;
    bit  flt = (a % (32'd1 << sz)) != 0;
    v64 = 1; we64 = we; a64 = a; wd64 = wd; sz64 = sz; tag64 = tag; se64 = se;
    if (k < halt_from && k + LAT + 1 < NMAX) begin
      if (we) begin
        if (flt) exp_f[k+1] = 1'b1;
        else if (a == TOHOST) begin
          exp_thv[k+1] = 1'b1;
          exp_thd[k+1] = wd[31:0];
          halt_from    = k + 1;
        end else begin
          for (int i = 0; i < (1 << sz); i++) mb[byte_base(a) + i] = wd[8*i +: 8];
        end
      end else begin
        exp_v[k+LAT]   = 1'b1;
        exp_tag[k+LAT] = tag;
        exp_f[k+LAT]   = exp_f[k+LAT] | flt;
        exp_d[k+LAT]   = flt ? 64'd0 : model_load(a, sz, se);
      end
    end
    @(negedge clock); #1;
    v64 = 0;
  endtask

  task automatic idle(input int n);
    v64 = 0;
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic do_reset(input int n);
    int k = neg_cnt;
    reset_n = 1'b0;
    for (int i = k + 1; i < NMAX; i++) begin
      exp_v[i] = 0; exp_tag[i] = 0; exp_d[i] = 0; exp_f[i] = 0; exp_thv[i] = 0; exp_thd[i] = 0;
    end
    halt_from = INF;
    repeat (n) begin @(negedge clock); #1; end
    reset_n = 1'b1;
  endtask

  // 32-bit instance: one request, results checked at the next falling edge
  task automatic req32(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic [4:0] tag, input logic se,
                       input logic ev, input logic [4:0] et, input logic [31:0] ed,
                       input logic ef);
    v32 = 1; we32 = we; a32 = a; wd32 = wd; sz32 = sz; tag32 = tag; se32 = se;
    @(negedge clock);
    chk("x32_valid", 64'(rdv32), 64'(ev));
    chk("x32_tag", 64'(rtag32), 64'(et));
    chk("x32_data", 64'(rd32), 64'(ed));
    chk("x32_fault", 64'(flt32), 64'(ef));
    chk("x32_ready", 64'(r32), 64'd1);
    #1;
    v32 = 0;
  endtask

  // Per-cycle comparison of every 64-bit instance output against the expectation tables
  initial begin
    forever begin
      @(negedge clock);
      neg_cnt++;
      if (neg_cnt < NMAX) begin
        chk("ready", 64'(r64), 64'(neg_cnt < halt_from));
        chk("rd_valid", 64'(rdv64), 64'(exp_v[neg_cnt]));
        chk("rd_tag", 64'(rtag64), 64'(exp_tag[neg_cnt]));
        chk("rd_data", rd64, exp_d[neg_cnt]);
        chk("fault", 64'(flt64), 64'(exp_f[neg_cnt]));
        chk("tohost_valid", 64'(thv64), 64'(exp_thv[neg_cnt]));
        if (exp_thv[neg_cnt]) chk("tohost_data", 64'(thd64), 64'(exp_thd[neg_cnt]));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;

    // Fill the whole array so no load ever returns uninitialised data
    for (int w = 0; w < (1 << DLG2); w++) req64(1, 32'(w * 8), {$urandom, $urandom}, 3, 0, 0);

    // Doubleword round trip, byte merge, signed/unsigned byte, reload
    req64(1, 32'h100, 64'h1122_3344_5566_7788, 3, 0, 0);
    req64(0, 32'h100, 0, 3, 7, 0);
    req64(1, 32'h103, 64'h80, 0, 0, 0);
    req64(0, 32'h103, 0, 0, 1, 1);
    req64(0, 32'h103, 0, 0, 2, 0);
    req64(0, 32'h100, 0, 3, 3, 0);
    idle(LAT);

    // Back-to-back loads with tags 1..4
    req64(0, 32'h100, 0, 3, 1, 0);
    req64(0, 32'h104, 0, 2, 2, 1);
    req64(0, 32'h106, 0, 1, 3, 1);
    req64(0, 32'h107, 0, 0, 4, 1);
    idle(LAT);

    // Misaligned load, misaligned store, then reload to show memory untouched
    req64(0, 32'h101, 0, 1, 9, 0);
    req64(1, 32'h102, 64'hAAAA_BBBB, 2, 0, 0);
    req64(0, 32'h100, 0, 3, 10, 0);
    // Load-then-store and store-then-load on the same word
    req64(0, 32'h20, 0, 3, 11, 0);
    req64(1, 32'h20, 64'h5555_6666_7777_8888, 3, 0, 0);
    req64(0, 32'h20, 0, 3, 12, 0);
    idle(LAT + 1);

    // Random mix, mostly aligned, upper address bits exercise aliasing
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom % 4);
      a  = $urandom & 32'h7FFF_FFFF;
      if ($urandom % 4 != 0) a = a & ~((32'd1 << sz) - 32'd1);
      req64(1'($urandom % 2), a, {$urandom, $urandom}, sz, 5'($urandom), 1'($urandom));
      if ($urandom % 5 == 0) idle(1);
    end
    idle(LAT + 1);

    // Narrow instance: word/half/byte plus oversize faults
    req32(1, 32'h10, 32'hCAFE_BABE, 2, 0, 0, 0, 0, 0, 0);
    req32(0, 32'h10, 0, 2, 3, 0, 1, 3, 32'hCAFE_BABE, 0);
    req32(0, 32'h12, 0, 1, 6, 1, 1, 6, 32'hFFFF_CAFE, 0);
    req32(0, 32'h10, 0, 3, 4, 0, 1, 4, 0, 1);
    req32(1, 32'h10, 32'h1234_5678, 3, 0, 0, 0, 0, 0, 1);
    req32(0, 32'h11, 0, 0, 2, 0, 1, 2, 32'h0000_00BA, 0);

    // In-flight load, store, tohost, then requests that must be ignored
    req64(0, 32'h18, 0, 3, 5, 0);
    req64(1, 32'h28, 64'h0BAD_F00D_0BAD_F00D, 3, 0, 0);
    req64(1, TOHOST, 64'hDEAD_BEEF, 2, 0, 0);
    req64(1, 32'h28, 64'h1234, 3, 0, 0);
    req64(0, 32'h28, 0, 3, 6, 0);
    idle(LAT + 2);
    do_reset(2);
    req64(0, 32'h28, 0, 3, 8, 0);
    req64(0, 32'h0, 0, 3, 13, 0);
    idle(LAT + 1);

    // Reset two cycles after a load is accepted: that load never reports
    req64(0, 32'h100, 0, 3, 14, 0);
    idle(1);
    do_reset(2);
    idle(LAT + 2);
    req64(0, 32'h100, 0, 3, 15, 0);
    idle(LAT + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
